// File: rtl/fetch_pc_stack_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pc_stack_pkg
// Shared CPU definitions for the fetch stage and the program memory:
//   PC_W      program-counter / instruction-address width (1024-word memory)
//   PC_RESET  address fetched first after reset
//   pc_sel_e  next-PC select encoding; the control unit decodes it into the
//             jump/call/ret strobes seen by fetch_pc_stack
// ----------------------------------------------------------------------------
package fetch_pc_stack_pkg;

  localparam int PC_W     = 10;
  localparam int PC_RESET = 0;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_JUMP = 2'd1,
    SEL_CALL = 2'd2,
    SEL_RET  = 2'd3
  } pc_sel_e;

endpackage : fetch_pc_stack_pkg

// File: rtl/fetch_pc_stack_ret_stack.sv
// ----------------------------------------------------------------------------
// ret_stack
// Parameterised LIFO holding subroutine return addresses.
//   clk, reset  rising-edge clock, synchronous active-high reset (clears the
//               occupancy count only; entry contents are don't-care)
//   push        write push_data as the new top entry (ignored when full)
//   pop         discard the top entry (ignored when empty)
//   push_data   address to push
//   top         current top entry, entry[depth-1] (undefined when empty)
//   depth       number of valid entries
//   full/empty  occupancy status
// The caller never asserts push and pop together; if it did, push wins.
// ----------------------------------------------------------------------------
module ret_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [DW-1:0] cnt;

  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;

  // Entry index equals occupancy: push writes entry[cnt], top reads entry[cnt-1].
  assign top = mem[IW'(cnt - DW'(1))];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end
  end

  // Storage carries no reset; stale entries above cnt are never observed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[IW'(cnt)] <= push_data;
    end
  end

endmodule : ret_stack

// File: rtl/fetch_pc_stack.sv
// ----------------------------------------------------------------------------
// fetch_pc_stack
// Program counter and next-address sequencing for the single-cycle CPU.
//   clk, reset       rising-edge clock, synchronous active-high reset
//   stall            hold pc, stack and flags this cycle
//   jump             pc <= target
//   call             push pc+1, pc <= target
//   ret              pop return stack into pc
//   target           jump/call destination
//   pc               registered instruction address (program memory address)
//   pc_next_seq      pc+1 modulo 2^AW (combinational)
//   depth            valid return-stack entries
//   stack_overflow   sticky: push attempted while full
//   stack_underflow  sticky: pop attempted while empty
// Edge priority: reset > stall > ret > call > jump > sequential.
// ----------------------------------------------------------------------------
module fetch_pc_stack
  import fetch_pc_stack_pkg::*;
#(
  parameter int            AW       = PC_W,
  parameter int            DEPTH    = 8,
  parameter logic [AW-1:0] RESET_PC = AW'(PC_RESET)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic [AW-1:0]                target,
  output logic [AW-1:0]                pc,
  output logic [AW-1:0]                pc_next_seq,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int DW = $clog2(DEPTH + 1);

  pc_sel_e       sel;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] stk_top;
  logic          stk_full;
  logic          stk_empty;
  logic          stk_push;
  logic          stk_pop;

  // pc+1 in AW bits wraps naturally from all-ones to zero.
  assign pc_next_seq = pc + AW'(1);

  // ret outranks call, which outranks jump; call+jump is therefore a call.
  always_comb begin
    sel = SEL_SEQ;
    if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (jump) begin
      sel = SEL_JUMP;
    end
  end

  // Stack moves only on a legal, unstalled push/pop; the failing cases only
  // raise a flag, so the stack never sees both strobes in one cycle.
  assign stk_push = !stall && (sel == SEL_CALL) && !stk_full;
  assign stk_pop  = !stall && (sel == SEL_RET)  && !stk_empty;

  always_comb begin
    pc_d = pc_next_seq;
    unique case (sel)
      SEL_RET:  pc_d = stk_empty ? pc_next_seq : stk_top;
      SEL_CALL: pc_d = target;
      SEL_JUMP: pc_d = target;
      default:  pc_d = pc_next_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_PC;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      pc <= pc_d;
      if ((sel == SEL_CALL) && stk_full) begin
        stack_overflow <= 1'b1;
      end
      if ((sel == SEL_RET) && stk_empty) begin
        stack_underflow <= 1'b1;
      end
    end
  end

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_next_seq),
    .top       (stk_top),
    .depth     (depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

endmodule : fetch_pc_stack

// File: tb/tb_fetch_pc_stack.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_stack
// Directed bench for fetch_pc_stack. Each step drives the controls, derives
// the expected post-edge state from a behavioural return-stack model, queues
// it, and compares it against the DUT one time unit after the rising edge.
// Fixed addresses from the intended behaviour are also checked directly.
// ----------------------------------------------------------------------------
module tb_fetch_pc_stack;

  localparam int AW    = 10;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [3:0]    depth;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          jump;
  logic          call;
  logic          ret;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next_seq;
  logic [3:0]    depth;
  logic          stack_overflow;
  logic          stack_underflow;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [AW-1:0] mpc;
  logic [AW-1:0] mstk [$];
  logic          movf;
  logic          munf;
  exp_t          sb [$];

  fetch_pc_stack #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .jump            (jump),
    .call            (call),
    .ret             (ret),
    .target          (target),
    .pc              (pc),
    .pc_next_seq     (pc_next_seq),
    .depth           (depth),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic j, input logic c,
                      input logic rt, input logic [AW-1:0] t);
    exp_t          e;
    logic [AW-1:0] link;
    reset  = r;
    stall  = s;
    jump   = j;
    call   = c;
    ret    = rt;
    target = t;
    #1;
    chk("pc_next_seq", {22'd0, pc_next_seq}, {22'd0, pc + 10'd1});
    link = mpc + 10'd1;
    if (r) begin
      mpc  = '0;
      mstk.delete();
      movf = 1'b0;
      munf = 1'b0;
    end else if (!s) begin
      if (rt) begin
        if (mstk.size() > 0) mpc = mstk.pop_back();
        else begin
          mpc  = link;
          munf = 1'b1;
        end
      end else if (c) begin
        if (mstk.size() < DEPTH) mstk.push_back(link);
        else movf = 1'b1;
        mpc = t;
      end else if (j) begin
        mpc = t;
      end else begin
        mpc = link;
      end
    end
    e.pc    = mpc;
    e.depth = 4'(mstk.size());
    e.ovf   = movf;
    e.unf   = munf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc",              {22'd0, pc},              {22'd0, e.pc});
    chk("depth",           {28'd0, depth},           {28'd0, e.depth});
    chk("stack_overflow",  {31'd0, stack_overflow},  {31'd0, e.ovf});
    chk("stack_underflow", {31'd0, stack_underflow}, {31'd0, e.unf});
  endtask

  initial begin
    mpc    = '0;
    movf   = 1'b0;
    munf   = 1'b0;
    reset  = 1'b1;
    stall  = 1'b0;
    jump   = 1'b0;
    call   = 1'b0;
    ret    = 1'b0;
    target = '0;
    @(negedge clk);

    // Reset then free-running sequential fetch
    step(1, 0, 0, 0, 0, 10'h000);
    chk("reset_pc", {22'd0, pc}, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 10'h000);
    chk("seq_pc5", {22'd0, pc}, 32'h5);

    // Call from pc=3, two sequential cycles, return to 0x004
    step(0, 0, 1, 0, 0, 10'h003);
    step(0, 0, 0, 1, 0, 10'h100);
    chk("call_pc", {22'd0, pc}, 32'h100);
    chk("call_depth", {28'd0, depth}, 32'h1);
    step(0, 0, 0, 0, 0, 10'h000);
    step(0, 0, 0, 0, 0, 10'h000);
    chk("seq_after_call", {22'd0, pc}, 32'h102);
    step(0, 0, 0, 0, 1, 10'h000);
    chk("ret_pc", {22'd0, pc}, 32'h004);
    chk("ret_depth", {28'd0, depth}, 32'h0);

    // call+ret together: ret wins (empty stack -> underflow comes later, so
    // prime one entry first); call+jump together: treated as call
    step(0, 0, 0, 1, 0, 10'h040);
    step(0, 0, 0, 1, 1, 10'h077);
    chk("callret_pc", {22'd0, pc}, 32'h005);
    step(0, 0, 1, 1, 0, 10'h080);
    chk("calljump_depth", {28'd0, depth}, 32'h1);
    step(0, 0, 0, 0, 1, 10'h000);
    chk("calljump_ret", {22'd0, pc}, 32'h006);

    // Eight nested calls then a ninth that overflows
    for (int i = 1; i <= DEPTH; i++) step(0, 0, 0, 1, 0, 10'(i * 32));
    step(0, 0, 0, 1, 0, 10'h200);
    chk("ovf_pc", {22'd0, pc}, 32'h200);
    chk("ovf_depth", {28'd0, depth}, 32'h8);
    chk("ovf_flag", {31'd0, stack_overflow}, 32'h1);
    step(0, 0, 0, 0, 1, 10'h000);
    chk("first_pop", {22'd0, pc}, 32'h0E1);
    for (int i = 1; i < DEPTH; i++) step(0, 0, 0, 0, 1, 10'h000);
    chk("last_pop", {22'd0, pc}, 32'h007);

    // Underflow at 0x050, then a normal call still pushes
    step(0, 0, 1, 0, 0, 10'h050);
    step(0, 0, 0, 0, 1, 10'h000);
    chk("unf_pc", {22'd0, pc}, 32'h051);
    chk("unf_flag", {31'd0, stack_underflow}, 32'h1);
    step(0, 0, 0, 1, 0, 10'h300);
    chk("call_after_unf", {28'd0, depth}, 32'h1);
    step(0, 0, 0, 0, 1, 10'h000);
    chk("ret_after_unf", {22'd0, pc}, 32'h052);

    // Wrap at 0x3FF for sequential fetch and for the pushed link address
    step(0, 0, 1, 0, 0, 10'h3FF);
    step(0, 0, 0, 0, 0, 10'h000);
    chk("wrap_seq", {22'd0, pc}, 32'h000);
    step(0, 0, 1, 0, 0, 10'h3FF);
    step(0, 0, 0, 1, 0, 10'h010);
    step(0, 0, 0, 0, 1, 10'h000);
    chk("wrap_link", {22'd0, pc}, 32'h000);

    // Build depth 3 at pc=0x2A0, stall with call asserted, then reset mid-call
    step(0, 0, 0, 1, 0, 10'h010);
    step(0, 0, 0, 1, 0, 10'h020);
    step(0, 0, 0, 1, 0, 10'h2A0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 10'h123);
    chk("stall_pc", {22'd0, pc}, 32'h2A0);
    chk("stall_depth", {28'd0, depth}, 32'h3);
    step(1, 0, 0, 1, 0, 10'h123);
    chk("rst_pc", {22'd0, pc}, 32'h0);
    chk("rst_depth", {28'd0, depth}, 32'h0);
    chk("rst_flags", {30'd0, stack_overflow, stack_underflow}, 32'h0);
    step(0, 0, 0, 0, 0, 10'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_pc_stack
